// File: rtl/sha3512_round_ctrl.sv
// SHA3-512 state-register sequencer: absorbs padded rate blocks, steps keccak-p rounds, flags the digest.
// Optional feature macro SHA3_CTRL_ABORT_EN adds inAbort, which drops the current message back to INIT.
module sha3512_round_ctrl #(
  parameter int unsigned NROUNDS = 24,
  parameter int unsigned RW      = 5
) (
  input  logic          inClk,
  input  logic          inRst,
  input  logic          inBlkValid,
  input  logic          inBlkLast,
`ifdef SHA3_CTRL_ABORT_EN
  input  logic          inAbort,
`endif
  output logic          outBlkReady,
  output logic          outInit,
  output logic          outExtWr,
  output logic          outIntWr,
  output logic [RW-1:0] outRound,
  output logic          outBusy,
  output logic          outDigestValid,
  input  logic          inDigestAck
);

  typedef enum logic [1:0] {INIT, WAIT_BLK, ROUND, DONE} state_e;

  localparam logic [RW-1:0] LAST_RND = RW'(NROUNDS - 1);

  state_e        state_q;
  logic [RW-1:0] cnt_q;
  logic          last_q;
  logic          busy_q;
  logic          init_q;
  logic          ready_q;
  logic          intwr_q;
  logic          dv_q;
  logic          abort_c;
  logic          hs_c;

`ifdef SHA3_CTRL_ABORT_EN
  assign abort_c = inAbort & (state_q != INIT);
`else
  assign abort_c = 1'b0;
`endif

  // An abort masks ready and the round strobe in the same cycle so nothing is written.
  assign outBlkReady    = ready_q & ~abort_c;
  assign hs_c           = inBlkValid & outBlkReady;
  assign outExtWr       = hs_c;
  assign outIntWr       = intwr_q & ~abort_c;
  assign outInit        = init_q;
  assign outRound       = cnt_q;
  assign outBusy        = busy_q;
  assign outDigestValid = dv_q;

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      init_q  <= 1'b1;
      ready_q <= 1'b0;
      intwr_q <= 1'b0;
      dv_q    <= 1'b0;
    end else if (abort_c) begin
      state_q <= INIT;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      init_q  <= 1'b1;
      ready_q <= 1'b0;
      intwr_q <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          state_q <= WAIT_BLK;
          init_q  <= 1'b0;
          ready_q <= 1'b1;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        WAIT_BLK: begin
          if (hs_c) begin
            state_q <= ROUND;
            last_q  <= inBlkLast;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            intwr_q <= 1'b1;
          end
        end
        ROUND: begin
          // The terminal round index is the only way out of ROUND.
          if (cnt_q == LAST_RND) begin
            cnt_q   <= '0;
            intwr_q <= 1'b0;
            if (last_q) begin
              state_q <= DONE;
              dv_q    <= 1'b1;
            end else begin
              state_q <= WAIT_BLK;
              ready_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + RW'(1);
          end
        end
        DONE: begin
          if (inDigestAck) begin
            state_q <= INIT;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            init_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= INIT;
          init_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha3512_round_ctrl.sv
// Scoreboard bench for sha3512_round_ctrl: stimulus queues expected strobe events, a monitor pops them.
module tb_sha3512_round_ctrl;

  localparam int NR = 24;
  localparam int RW = 5;

  typedef enum logic [1:0] {EV_INIT, EV_EXT, EV_INT, EV_DIG} ev_kind_e;
  typedef struct {
    ev_kind_e        kind;
    logic [RW-1:0]   rnd;
    int              cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          inBlkValid, inBlkLast, inDigestAck;
  logic          outBlkReady, outInit, outExtWr, outIntWr, outBusy, outDigestValid;
  logic [RW-1:0] outRound;
`ifdef SHA3_CTRL_ABORT_EN
  logic          inAbort;
`endif

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  n_ext = 0;
  int  n_int = 0;
  int  last_hs = 0;
  logic prev_dv = 1'b0;

  sha3512_round_ctrl #(.NROUNDS(NR), .RW(RW)) dut (
    .inClk          (clk),
    .inRst          (rst),
    .inBlkValid     (inBlkValid),
    .inBlkLast      (inBlkLast),
`ifdef SHA3_CTRL_ABORT_EN
    .inAbort        (inAbort),
`endif
    .outBlkReady    (outBlkReady),
    .outInit        (outInit),
    .outExtWr       (outExtWr),
    .outIntWr       (outIntWr),
    .outRound       (outRound),
    .outBusy        (outBusy),
    .outDigestValid (outDigestValid),
    .inDigestAck    (inDigestAck)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [RW-1:0] r);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s rnd=%0d cyc=%0d expected no event", k.name(), r, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.rnd != r || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got %s rnd=%0d cyc=%0d expected %s rnd=%0d cyc=%0d",
                 k.name(), r, cyc, e.kind.name(), e.rnd, e.cyc);
      end
    end
  endtask

  // Monitor: every strobe the DUT raises must match the head of the expected queue.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("excl_ext_int", 32'(outExtWr & outIntWr), 32'd0);
      check("excl_init", 32'(outInit & (outExtWr | outIntWr)), 32'd0);
      if (outInit) expect_ev(EV_INIT, '0);
      if (outExtWr) begin n_ext++; expect_ev(EV_EXT, '0); end
      if (outIntWr) begin n_int++; expect_ev(EV_INT, outRound); end
      if (outDigestValid && !prev_dv) expect_ev(EV_DIG, '0);
    end
    prev_dv = outDigestValid;
  end

  // Present a block (valid stays high afterwards) and queue its absorb, rounds and digest.
  task automatic send_block(input logic last, input logic chk_slot, input int slot);
    bit got;
    int k;
    got = 0;
    inBlkValid = 1'b1;
    inBlkLast  = last;
    for (int i = 0; i < 200 && !got; i++) begin
      if (outBlkReady) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: got no outBlkReady in 200 cycles expected ready");
    end else begin
      k = cyc;
      if (chk_slot) check("ready_slot", k, slot);
      exp_q.push_back('{EV_EXT, '0, k});
      for (int r = 0; r < NR; r++) exp_q.push_back('{EV_INT, RW'(r), k + 1 + r});
      if (last) exp_q.push_back('{EV_DIG, '0, k + 1 + NR});
      last_hs = k;
      @(posedge clk); #1;
      inBlkLast = ~last;
    end
  endtask

  task automatic digest_and_ack();
    bit got;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (outDigestValid) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL digest_timeout: got no outDigestValid in 200 cycles expected digest");
    end
    check("dig_cycle", cyc, last_hs + NR + 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("dig_hold", {outDigestValid, outBusy, outBlkReady, outIntWr}, 4'b1100);
    end
    inDigestAck = 1'b1;
    exp_q.push_back('{EV_INIT, '0, cyc + 1});
    @(posedge clk); #1;
    inDigestAck = 1'b0;
    @(posedge clk); #1;
    check("post_ack", {outBlkReady, outBusy, outDigestValid, outInit}, 4'b1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_ext, base_int;
    rst = 1'b1; inBlkValid = 1'b0; inBlkLast = 1'b0; inDigestAck = 1'b0;
`ifdef SHA3_CTRL_ABORT_EN
    inAbort = 1'b0;
`endif
    repeat (3) @(posedge clk); #1;
    check("rst_vals", {outInit, outBlkReady, outExtWr, outIntWr, outBusy, outDigestValid, outRound},
          {6'b100000, 5'd0});
    rst = 1'b0;
    exp_q.push_back('{EV_INIT, '0, cyc});
    @(posedge clk); #1;
    check("idle_wait", {outInit, outBlkReady, outExtWr, outIntWr, outBusy, outDigestValid}, 6'b010000);

    // Single-block message.
    send_block(1'b1, 1'b0, 0);
    inBlkValid = 1'b0;
    digest_and_ack();

    // Three blocks with valid held and a stray ack during rounds.
    base_ext = n_ext; base_int = n_int;
    send_block(1'b0, 1'b0, 0);
    inDigestAck = 1'b1;
    send_block(1'b0, 1'b1, last_hs + NR + 1);
    send_block(1'b1, 1'b1, last_hs + NR + 1);
    inBlkValid = 1'b0; inDigestAck = 1'b0;
    digest_and_ack();
    check("ext_pulses", n_ext - base_ext, 3);
    check("int_cycles", n_int - base_int, 3 * NR);

    // Reset in round 10 of the second block.
    send_block(1'b0, 1'b0, 0);
    send_block(1'b1, 1'b1, last_hs + NR + 1);
    repeat (10) @(posedge clk); #1;
    check("round10", outRound, 10);
    rst = 1'b1; inBlkValid = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_vals", {outInit, outBlkReady, outExtWr, outIntWr, outBusy, outDigestValid, outRound},
          {6'b100000, 5'd0});
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back('{EV_INIT, '0, cyc});
    @(posedge clk); #1;
    send_block(1'b1, 1'b0, 0);
    inBlkValid = 1'b0;
    digest_and_ack();

`ifdef SHA3_CTRL_ABORT_EN
    send_block(1'b1, 1'b0, 0);
    inBlkValid = 1'b0;
    repeat (5) @(posedge clk); #1;
    inAbort = 1'b1;
    exp_q.delete();
    #1;
    check("abort_strobes", {outIntWr, outExtWr, outBlkReady}, 3'b000);
    exp_q.push_back('{EV_INIT, '0, cyc + 1});
    @(posedge clk); #1;
    inAbort = 1'b0;
    check("abort_init", {outInit, outBusy, outDigestValid}, 3'b100);
    @(posedge clk); #1;
    inAbort = 1'b1; inBlkValid = 1'b1;
    #1;
    check("abort_hs", {outExtWr, outBlkReady}, 2'b00);
    exp_q.push_back('{EV_INIT, '0, cyc + 1});
    @(posedge clk); #1;
    inAbort = 1'b0; inBlkValid = 1'b0;
    repeat (30) @(posedge clk); #1;
    check("abort_no_dig", {outDigestValid, outBusy, outBlkReady}, 3'b001);
`endif

    repeat (3) @(posedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
